timer_wrapper_unit: RTL and testbench
=====================================

TIMER_WRAPPER_UNIT -- requirements
Module: timer_wrapper_unit

Interface
REQ-001 Parameter CNT_W, default 30: width of the initial-value register and down-counter.
REQ-002 Parameter PSC_W, default 5: width of the prescaler exponent field taken from data_in[PSC_W-1:0].
REQ-003 The block SHALL have one clock and a synchronous, active-high reset.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 reset_n  input  1  synchronous active-high reset, sampled on clk rising edge (name kept per codebase; asserted = 1).
REQ-006 data_in  input  32  command word: [31:30] opcode, [29:0] payload; sampled every rising edge.
REQ-007 data_out  output  32  status: [0] done, [1] running, [31:2] zero.

Function
REQ-008 Opcode 2'b00 (LOAD_INIT) SHALL write payload[CNT_W-1:0] into INIT register.
REQ-009 Opcode 2'b01 (LOAD_PSC) SHALL write payload[PSC_W-1:0] into PSC register; payload[29:PSC_W] ignored.
REQ-010 Opcode 2'b10 (DISABLE) SHALL enter IDLE: running=0, done=0, counters held.
REQ-011 Opcode 2'b11 (ENABLE) SHALL start a run only when in IDLE; while RUNNING or DONE it is a no-op, so a level-held ENABLE never restarts the timer.
REQ-012 Commands are level-sampled: holding any opcode for several cycles SHALL have the same effect as one cycle.
REQ-013 States: IDLE, RUNNING, DONE; IDLE->RUNNING on ENABLE; RUNNING->DONE on terminal count; RUNNING/DONE->IDLE on DISABLE; DONE holds until DISABLE.
REQ-014 On the edge that starts a run, count SHALL load INIT and prescale counter SHALL load 0.
REQ-015 Run length SHALL be N = INIT * 2^PSC clock cycles: prescale counter increments each edge while RUNNING; when it reaches 2^PSC-1 it wraps to 0 and count decrements.
REQ-016 done SHALL be registered and rise on the edge exactly N edges after the edge that sampled ENABLE (edge 0), visible on data_out[0] from that edge onward.
REQ-017 INIT=0 SHALL produce done on edge 0 itself (go straight to DONE).
REQ-018 done SHALL be sticky in DONE; counters stop; running=0 in DONE, 1 in RUNNING.
REQ-019 LOAD_INIT/LOAD_PSC while RUNNING SHALL update registers only; the active run is unaffected; new values apply at the next start.
REQ-020 Prescale counter SHALL be 2^PSC_W-1 bits wide so PSC up to 31 cannot overflow; count decrement SHALL never wrap below 0.

Reset
REQ-021 reset_n=1 at a rising edge SHALL force IDLE, INIT=0, PSC=0, count=0, prescale=0, data_out=0; reset overrides any same-cycle command.
REQ-022 Reset asserted mid-run SHALL abort the run; after release, ENABLE is required to start again.

Verification
REQ-023 Reset; DISABLE; LOAD_INIT 250; LOAD_PSC 2; ENABLE held -> data_out[0] rises exactly 1000 cycles after enable edge.
REQ-024 Following REQ-023 without reset: DISABLE; LOAD_INIT 500; LOAD_PSC 4; ENABLE held -> done after exactly 8000 cycles; done cleared by the DISABLE.
REQ-025 LOAD_INIT 0, ENABLE -> done high on enable edge; stays high while ENABLE held; DISABLE -> data_out=0.
REQ-026 INIT 10, PSC 0, ENABLE; at cycle 5 LOAD_INIT 3 -> done still at cycle 10; re-enable after DISABLE -> done at 3 cycles.
REQ-027 INIT 100, PSC 1, ENABLE; reset_n=1 at cycle 50 -> data_out=0, no done appears while ENABLE held after reset until DISABLE then ENABLE.

Source files
------------

// File: rtl/timer_wrapper_unit_if.sv
// Command/status bus for timer_wrapper_unit.
// The master drives command words and the slave (the timer) returns status.
interface timer_wrapper_unit_if;
  logic [31:0] data_in;   // [31:30] opcode, [29:0] payload
  logic [31:0] data_out;  // [0] done, [1] running, [31:2] zero

  modport master (
    output data_in,
    input  data_out
  );

  modport slave (
    input  data_in,
    output data_out
  );
endinterface

// File: rtl/timer_wrapper_unit.sv
// Command-driven one-shot timer.
// A run lasts INIT * 2^PSC cycles, and done is held until DISABLE.
// Commands are sampled on every edge.
module timer_wrapper_unit #(
  parameter int unsigned CNT_W = 30,
  parameter int unsigned PSC_W = 5
) (
  input logic                 clk,
  input logic                 reset_n,  // active-high synchronous reset despite the name
  timer_wrapper_unit_if.slave bus
);

  // Wide enough to count to 2^PSC - 1 for any PSC value.
  localparam int unsigned PscCntW = (1 << PSC_W) - 1;

  localparam logic [1:0] OpLoadInit = 2'b00;
  localparam logic [1:0] OpLoadPsc  = 2'b01;
  localparam logic [1:0] OpDisable  = 2'b10;
  localparam logic [1:0] OpEnable   = 2'b11;

  typedef enum logic [1:0] {StIdle, StRunning, StDone} state_e;

  state_e               r_state, w_state_nxt;
  logic [CNT_W-1:0]     r_init;
  logic [PSC_W-1:0]     r_psc;
  logic [CNT_W-1:0]     r_count, w_count_nxt;
  logic [PscCntW-1:0]   r_pcnt, w_pcnt_nxt;
  // Reset clears this flag. Only DISABLE sets it.
  // A level-held ENABLE that spans a reset therefore cannot start a new run.
  logic                 r_armed;

  logic [1:0]           w_op;
  logic [PSC_W-1:0]     w_shamt;
  logic [PscCntW-1:0]   w_psc_max;

  assign w_op      = bus.data_in[31:30];
  assign w_shamt   = PSC_W'(PscCntW) - r_psc;
  assign w_psc_max = {PscCntW{1'b1}} >> w_shamt;  // 2^PSC - 1

  // Next-state logic: DISABLE takes priority, then the state-specific behaviour.
  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    w_pcnt_nxt  = r_pcnt;
    if (w_op == OpDisable) begin
      w_state_nxt = StIdle;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (w_op == OpEnable && r_armed) begin
            w_count_nxt = r_init;
            w_pcnt_nxt  = '0;
            w_state_nxt = (r_init == '0) ? StDone : StRunning;
          end
        end
        StRunning: begin
          if (r_pcnt == w_psc_max) begin
            w_pcnt_nxt = '0;
            if (r_count != '0) w_count_nxt = r_count - CNT_W'(1);
            if (r_count <= CNT_W'(1)) w_state_nxt = StDone;
          end else begin
            w_pcnt_nxt = r_pcnt + PscCntW'(1);
          end
        end
        StDone: ;
        default: w_state_nxt = StIdle;
      endcase
    end
  end

  // State and configuration registers; reset overrides any command in the same cycle.
  always_ff @(posedge clk) begin
    if (reset_n) begin
      r_state <= StIdle;
      r_init  <= '0;
      r_psc   <= '0;
      r_count <= '0;
      r_pcnt  <= '0;
      r_armed <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
      r_pcnt  <= w_pcnt_nxt;
      if (w_op == OpLoadInit) r_init <= bus.data_in[CNT_W-1:0];
      if (w_op == OpLoadPsc)  r_psc  <= bus.data_in[PSC_W-1:0];
      if (w_op == OpDisable)  r_armed <= 1'b1;
    end
  end

  assign bus.data_out = {30'd0, r_state == StRunning, r_state == StDone};

endmodule

// File: tb/tb_timer_wrapper_unit.sv
// Directed bench for timer_wrapper_unit.
// Inputs are driven and outputs are sampled 1 ns after each rising edge.
module tb_timer_wrapper_unit;
  logic clk = 1'b0;
  logic reset_n;
  int   n_checks = 0;
  int   n_pass   = 0;

  timer_wrapper_unit_if u_if ();

  timer_wrapper_unit u_dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (u_if)
  );

  always #5 clk = ~clk;

  localparam logic [31:0] StIdleV = 32'd0;
  localparam logic [31:0] StRunV  = 32'd2;
  localparam logic [31:0] StDoneV = 32'd1;

  function automatic logic [31:0] cmd(input logic [1:0] op, input logic [29:0] payload);
    return {op, payload};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  // Apply a command for n edges.
  task automatic step(input logic [31:0] c, input int n = 1);
    u_if.data_in = c;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Start a run from IDLE. After edge 0, check that the output still reads
  // running one edge before the end and reads done exactly at edge n.
  task automatic run_expect(input string tag, input int n);
    step(cmd(2'b11, 0));  // edge 0
    if (n == 0) begin
      check({tag, "_edge0_done"}, u_if.data_out, StDoneV);
    end else begin
      check({tag, "_edge0_run"}, u_if.data_out, StRunV);
      step(cmd(2'b11, 0), n - 1);
      check({tag, "_before_done"}, u_if.data_out, StRunV);
      step(cmd(2'b11, 0));
      check({tag, "_done"}, u_if.data_out, StDoneV);
    end
  endtask

  initial begin
    logic saw_activity;
    // Reset wins over an ENABLE presented in the same cycle.
    reset_n = 1'b1;
    u_if.data_in = cmd(2'b11, 0);
    step(cmd(2'b11, 0), 2);
    check("reset_out", u_if.data_out, StIdleV);
    reset_n = 1'b0;
    // Not yet armed: a held ENABLE must not start a run.
    step(cmd(2'b11, 0), 3);
    check("unarmed_enable", u_if.data_out, StIdleV);

    // INIT 250, PSC 2 -> 1000 cycles
    step(cmd(2'b10, 0));
    step(cmd(2'b00, 250));
    step(cmd(2'b01, 2));
    run_expect("r1000", 1000);
    step(cmd(2'b11, 0), 20);
    check("r1000_sticky", u_if.data_out, StDoneV);

    // INIT 500, PSC 4 -> 8000 cycles
    step(cmd(2'b10, 0));
    check("disable_clears", u_if.data_out, StIdleV);
    step(cmd(2'b00, 500));
    step(cmd(2'b01, 4));
    run_expect("r8000", 8000);

    // INIT 0 -> done on the enable edge
    step(cmd(2'b10, 0));
    step(cmd(2'b00, 0));
    run_expect("init0", 0);
    step(cmd(2'b11, 0), 5);
    check("init0_hold", u_if.data_out, StDoneV);
    step(cmd(2'b10, 0));
    check("init0_disable", u_if.data_out, StIdleV);

    // INIT 10, PSC 0, then reload INIT to 3 on edge 5 without disturbing the run
    step(cmd(2'b00, 10));
    step(cmd(2'b01, 0));
    step(cmd(2'b11, 0));  // edge 0
    step(cmd(2'b11, 0), 4);  // edges 1-4
    step(cmd(2'b00, 3));  // edge 5
    step(cmd(2'b11, 0), 4);  // edges 6-9
    check("reload_edge9", u_if.data_out, StRunV);
    step(cmd(2'b11, 0));  // edge 10
    check("reload_edge10", u_if.data_out, StDoneV);
    step(cmd(2'b10, 0));
    run_expect("reload_new", 3);

    // Upper payload bits of LOAD_PSC are ignored: 0x21 -> PSC 1; INIT 3 -> 6 cycles
    step(cmd(2'b10, 0));
    step(cmd(2'b00, 3));
    step(cmd(2'b01, 30'h21));
    run_expect("psc_mask", 6);

    // INIT 100, PSC 1; a reset at edge 50 aborts the run
    step(cmd(2'b10, 0));
    step(cmd(2'b00, 100));
    step(cmd(2'b01, 1));
    step(cmd(2'b11, 0), 50);  // edges 0-49
    check("abort_pre", u_if.data_out, StRunV);
    reset_n = 1'b1;
    step(cmd(2'b11, 0));  // edge 50
    check("abort_reset", u_if.data_out, StIdleV);
    reset_n = 1'b0;
    saw_activity = 1'b0;
    for (int i = 0; i < 300; i++) begin
      step(cmd(2'b11, 0));
      if (u_if.data_out != 32'd0) saw_activity = 1'b1;
    end
    check("abort_no_restart", {31'd0, saw_activity}, 32'd0);
    // INIT was cleared by reset, so a fresh start finishes on the enable edge.
    step(cmd(2'b10, 0));
    run_expect("abort_rearm", 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
